// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg
//   Shared definitions for the RAM stream reader slice:
//   - FSM state encoding (legacy-compatible localparam constants)
//   - init_wait_cycles(): length of the post-reset RAM clear window
package ram_stream_reader_pkg;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // The attached RAM is cleared word-by-word after reset; wait for the
    // whole array plus two cycles of pipeline margin before reading.
    function automatic int unsigned init_wait_cycles(input int unsigned addr_width);
        return (32'd1 << addr_width) + 32'd2;
    endfunction

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// stream_skid_fifo2
//   Two-entry output FIFO sitting between the RAM read pipeline and the
//   valid/ready stream. The head entry is held in a register so data stays
//   stable while the consumer stalls.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset (clears all entries)
//   push          - write push_data (caller never pushes when full)
//   push_data     - entry to store
//   pop           - remove head entry (ignored when empty)
//   head_data     - oldest entry
//   valid         - FIFO non-empty
//   count         - number of stored entries (0..2)
module stream_skid_fifo2 #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_pop;

    assign do_pop    = pop && valid;
    assign valid     = (count != 2'd0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Reads a burst of words from port B of a synchronous dual-port RAM and
//   presents them on a valid/ready stream with an end-of-burst marker.
//   After reset the block waits out the RAM clear window before accepting
//   any start.
// Ports:
//   clk        - clock, all state on rising edge
//   reset_n    - asynchronous active-low reset
//   start      - one-cycle burst launch (accepted only when idle, init done)
//   base_addr  - first word address, sampled with start
//   length     - word count, sampled with start (0 = no burst)
//   addr_b     - read address to RAM port B
//   dout_b     - RAM port B data, valid one cycle after addr_b
//   m_data     - stream data
//   m_valid    - stream data valid
//   m_ready    - downstream accept
//   m_last     - final word of the burst
//   busy       - burst in progress
//   init_done  - RAM clear window elapsed
// Configuration:
//   RAM_STREAM_READER_LOOP_EN - when defined, the burst repeats endlessly
//   from the latched base/length until reset.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] dout_b,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  init_done
);

    localparam int unsigned INIT_CYCLES = init_wait_cycles(ADDR_WIDTH);
    localparam int unsigned CW          = ADDR_WIDTH + 2;

    logic [1:0]            state;
    logic [CW-1:0]         init_cnt;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  rd_pend;
    logic                  rd_pend_last;
    logic [1:0]            fifo_count;
    logic [2:0]            occupancy;
    logic                  pop;
    logic                  issue;
    logic                  last_issue;
    logic                  fifo_valid;
    logic [DATA_WIDTH:0]   fifo_head;

`ifdef RAM_STREAM_READER_LOOP_EN
    logic [ADDR_WIDTH-1:0] base_lat;
    logic [ADDR_WIDTH:0]   len_lat;
`endif

    assign pop = m_valid && m_ready;

    // Count the word leaving this cycle so a steady m_ready sustains one
    // read per cycle while never overfilling the two-entry FIFO.
    assign occupancy  = {1'b0, fifo_count} + {2'b00, rd_pend} - {2'b00, pop};
    assign issue      = (state == ST_READ) && (occupancy < 3'd2);
    assign last_issue = issue && (remaining == (ADDR_WIDTH + 1)'(1));

    assign m_valid = fifo_valid;
    assign m_data  = fifo_head[DATA_WIDTH-1:0];
    assign m_last  = fifo_valid && fifo_head[DATA_WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_INIT;
            init_cnt     <= '0;
            init_done    <= 1'b0;
            busy         <= 1'b0;
            addr_b       <= '0;
            remaining    <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
`ifdef RAM_STREAM_READER_LOOP_EN
            base_lat     <= '0;
            len_lat      <= '0;
`endif
        end else begin
            rd_pend      <= issue;
            rd_pend_last <= last_issue;
            if (issue) begin
                addr_b    <= addr_b + ADDR_WIDTH'(1);
                remaining <= remaining - (ADDR_WIDTH + 1)'(1);
            end
            case (state)
                ST_INIT: begin
                    if (init_cnt == CW'(INIT_CYCLES - 1)) begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + CW'(1);
                    end
                end
                ST_IDLE: begin
                    if (start && (length != '0)) begin
                        addr_b    <= base_addr;
                        remaining <= length;
                        busy      <= 1'b1;
                        state     <= ST_READ;
`ifdef RAM_STREAM_READER_LOOP_EN
                        base_lat  <= base_addr;
                        len_lat   <= length;
`endif
                    end
                end
                ST_READ: begin
                    if (last_issue) begin
`ifdef RAM_STREAM_READER_LOOP_EN
                        // Reload as the last read issues (not at its
                        // transfer) so the next pass follows without a gap.
                        addr_b    <= base_lat;
                        remaining <= len_lat;
`else
                        state     <= ST_DRAIN;
`endif
                    end
                end
                ST_DRAIN: begin
                    if (pop && m_last) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    stream_skid_fifo2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rd_pend),
        .push_data ({rd_pend_last, dout_b}),
        .pop       (pop),
        .head_data (fifo_head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader
//   Directed bench for ram_stream_reader (ADDR_WIDTH=6, DATA_WIDTH=8) with a
//   synchronous RAM model preloaded addr=i data=i and a scoreboard of
//   expected {last,data} stream words.
//   Define RAM_STREAM_READER_LOOP_EN for both RTL and bench to cover the
//   looping build.
module tb_ram_stream_reader;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] dout_b;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          init_done;

    logic [DW-1:0] ram [64];
    logic [DW:0]   exp_q [$];

    int n_cmp;
    int n_err;
    int xfer_total;
    int n0;
    int init_early;
    bit mon_en;
    bit prev_stall;
    logic [DW:0] prev_word;

    ram_stream_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .addr_b    (addr_b),
        .dout_b    (dout_b),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = DW'(i);
    end

    always @(posedge clk) dout_b <= ram[addr_b];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input int base, input int len);
        for (int i = 0; i < len; i++) begin
            logic [DW:0] w;
            w[DW-1:0] = DW'((base + i) % 64);
            w[DW]     = (i == len - 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic pulse_start(input int base, input int len);
        base_addr = AW'(base);
        length    = (AW + 1)'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (busy === 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
    endtask

    // Stream monitor: sampled on the falling edge, a transfer happens at the
    // following rising edge.
    always @(negedge clk) begin
        if (!reset_n || !mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_word", {m_last, m_data}, prev_word);
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                xfer_total++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL unexpected_xfer: observed %0h expected none", {m_last, m_data});
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    check("xfer_word", {m_last, m_data}, e);
                end
            end
            prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
            prev_word  = {m_last, m_data};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_err = 0; xfer_total = 0; init_early = 0;
        mon_en    = 1'b1;
        reset_n   = 1'b0;
        start     = 1'b1;
        base_addr = AW'(5);
        length    = (AW + 1)'(4);
        m_ready   = 1'b1;
        repeat (3) tick();

        check("rst_addr_b", addr_b, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_init_done", init_done, 0);

        // Init window with start held high the whole time
        reset_n = 1'b1;
        for (int i = 1; i <= 65; i++) begin
            tick();
            if (init_done !== 1'b0 || busy !== 1'b0) init_early++;
        end
        check("init_hold_65", init_early, 0);
        tick();
        check("init_done_66", init_done, 1);
        check("init_busy_66", busy, 0);

        // First burst: start still high is accepted on the next edge
        push_burst(5, 4);
        tick();
        start = 1'b0;
        check("b1_busy", busy, 1);
        tick();
        check("b1_lat1_valid", m_valid, 0);
        tick();
        check("b1_lat2_valid", m_valid, 1);
        check("b1_first_data", m_data, 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b1_consecutive", m_valid, 1);
        end
        check("b1_last", m_last, 1);
        check("b1_last_data", m_data, 8);
        tick();
        check("b1_busy_after", busy, 0);
        check("b1_valid_after", m_valid, 0);
        check("b1_queue", exp_q.size(), 0);

        // Address wrap
        push_burst(62, 4);
        pulse_start(62, 4);
        check("wrap_addr0", addr_b, 62);
        tick();
        check("wrap_addr1", addr_b, 63);
        tick();
        check("wrap_addr2", addr_b, 0);
        tick();
        check("wrap_addr3", addr_b, 1);
        wait_idle("wrap_idle", 20);
        check("wrap_queue", exp_q.size(), 0);

        // Zero length: no burst
        pulse_start(9, 0);
        repeat (4) tick();
        check("len0_busy", busy, 0);
        check("len0_valid", m_valid, 0);

        // Random back-pressure, plus a start while busy that must be ignored
        n0 = xfer_total;
        push_burst(20, 10);
        pulse_start(20, 10);
        base_addr = AW'(50);
        length    = (AW + 1)'(3);
        for (int i = 0; i < 300 && busy === 1'b1; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            start   = (i == 6);
            tick();
        end
        start   = 1'b0;
        m_ready = 1'b1;
        wait_idle("rand_idle", 20);
        check("rand_count", xfer_total - n0, 10);
        check("rand_queue", exp_q.size(), 0);
        repeat (4) tick();
        check("rand_no_extra", xfer_total - n0, 10);

        // Reset in the middle of a burst
        n0 = xfer_total;
        push_burst(40, 8);
        pulse_start(40, 8);
        for (int i = 0; i < 50 && xfer_total < n0 + 3; i++) tick();
        check("mid_xfers", xfer_total - n0, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr_b", addr_b, 0);
        check("mid_rst_m_data", m_data, 0);
        check("mid_rst_m_last", m_last, 0);
        check("mid_rst_init_done", init_done, 0);
        exp_q.delete();
        n0 = xfer_total;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (80) tick();
        check("post_rst_init_done", init_done, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_no_xfer", xfer_total - n0, 0);

`ifdef RAM_STREAM_READER_LOOP_EN
        for (int k = 0; k < 5; k++) push_burst(0, 2);
        pulse_start(0, 2);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("loop_no_gap", m_valid, 1);
            check("loop_busy", busy, 1);
            tick();
        end
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("loop_rst_busy", busy, 0);
        check("loop_queue", exp_q.size(), 0);
`endif

        check("final_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
- REQ-001: Parameter ADDR_WIDTH, default 6; word address width of the attached dual-port RAM read port.
- REQ-002: Parameter DATA_WIDTH, default 8; RAM word width.
- REQ-003: clk  input  1  single clock; all state on rising edge.
- REQ-004: reset_n  input  1  reset, asynchronous and active-low.
- REQ-005: start  input  1  one-cycle pulse; launches a burst, ignored unless idle and init done.
- REQ-006: base_addr  input  ADDR_WIDTH  first word address, sampled with start.
- REQ-007: length  input  ADDR_WIDTH+1  words to read, sampled with start; 0 means no burst.
- REQ-008: addr_b  output  ADDR_WIDTH  read address to RAM port B.
- REQ-009: dout_b  input  DATA_WIDTH  RAM port B data, valid one cycle after addr_b is presented.
- REQ-010: m_data  output  DATA_WIDTH  stream data.
- REQ-011: m_valid  output  1  stream data valid.
- REQ-012: m_ready  input  1  downstream accept; transfer when m_valid and m_ready.
- REQ-013: m_last  output  1  marks final word of the burst.
- REQ-014: busy  output  1  high from accepted start until last word transferred.
- REQ-015: init_done  output  1  high once the RAM post-reset clear window has elapsed.

Function
- REQ-016: FSM states INIT, IDLE, READ, DRAIN; reset enters INIT.
- REQ-017: INIT counts 2**ADDR_WIDTH+2 cycles, then enters IDLE and sets init_done, which stays high until reset.
- REQ-018: IDLE with start and length!=0 latches base_addr/length, sets busy, enters READ; start with length==0 stays IDLE, no output.
- REQ-019: READ issues one read per cycle only if output buffer occupancy plus in-flight reads is below 2.
- REQ-020: Each issued read increments addr_b modulo 2**ADDR_WIDTH; wrap from all-ones to 0 is legal.
- REQ-021: Data returned by dout_b is captured the cycle after issue into a 2-entry output FIFO; no word dropped or duplicated under any m_ready pattern.
- REQ-022: Minimum latency start-to-m_valid is 2 cycles; with m_ready held high, throughput is one word per cycle.
- REQ-023: After the last read is issued, the FSM enters DRAIN; on transfer of the m_last word, busy drops and the FSM enters IDLE the same edge.
- REQ-024: m_last is high only with m_valid on the length-th word.
- REQ-025: start while busy is ignored.
- REQ-026: m_data and m_last hold stable while m_valid is high and m_ready is low.

Reset
- REQ-027: Reset assertion at any time aborts any burst and clears the FIFO.
- REQ-028: Reset values: addr_b=0, m_data=0, m_valid=0, m_last=0, busy=0, init_done=0, FSM=INIT.
- REQ-029: Reset deassertion restarts the full INIT wait.

Configuration
- REQ-030: Macro RAM_STREAM_READER_LOOP_EN defined: m_last transfer reloads the latched base_addr/length and re-enters READ without gap; busy stays high; the loop exits only via reset.
- REQ-031: Macro undefined: single-burst behaviour per REQ-023; loop logic absent.

Structure
- REQ-032: Shared package holds the FSM state encoding and the INIT wait-length constant function.
- REQ-033: Output FIFO is a sub-module, stream_skid_fifo2, 2 entries, parameterised by DATA_WIDTH+1 (data plus last).

Verification
- REQ-034: Reset released, start held high throughout -> start ignored for 66 cycles with ADDR_WIDTH=6; init_done rises on cycle 66.
- REQ-035: RAM preloaded addr=i data=i; base 5, length 4, m_ready=1 -> m_data 5,6,7,8 on consecutive cycles; m_last with 8; busy low after.
- REQ-036: Base 62, length 4 -> addr_b 62,63,0,1; data 62,63,0,1.
- REQ-037: Length 10, m_ready toggled with a random 50% duty -> exactly 10 transfers, in order, data stable while stalled.
- REQ-038: Reset asserted mid-burst after 3 transfers -> all outputs at reset values asynchronously; no transfer after reset deassertion without new start.
- REQ-039: Loop build, base 0, length 2 -> m_data 0,1,0,1,... with m_last on every 1, no idle cycle.
